// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_W          = 32;
    localparam int RESET_PC_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Small in-order buffer of {instruction, pc} words between memory and the core.
module ifetch_buf
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = INSTR_W + 16
) (
    input  logic         clk,
    input  logic         rst_f,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CW = 2;

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_ent   [DEPTH];
    logic [W-1:0]  w_shift [DEPTH];
    logic [CW-1:0] w_wr_idx;

    // A push in the same cycle as a pop lands one slot lower, behind the shifted head.
    assign w_wr_idx = r_cnt - {1'b0, i_pop};
    assign o_full   = (r_cnt == CW'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_data   = r_ent[0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_mid
            assign w_shift[g] = r_ent[g+1];
        end else begin : g_last
            assign w_shift[g] = r_ent[g];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f || i_flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (w_wr_idx == CW'(i))) begin
                    r_ent[i] <= i_data;
                end else if (i_pop) begin
                    r_ent[i] <= w_shift[i];
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, single-outstanding memory request FSM and redirect handling.
// IFETCH_PREFETCH_EN selects a 2-entry buffer so the next fetch overlaps a held word.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int AW       = 16,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               br_taken,
    input  logic [AW-1:0]      br_target,
    output logic [INSTR_W-1:0] instruction,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [AW-1:0]      ins_pc
);

`ifdef IFETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int ENT_W = INSTR_W + AW;

    fetch_state_t     r_state;
    logic [AW-1:0]    r_pc;
    logic             r_mem_req;
    logic [AW-1:0]    r_mem_addr;
    logic             r_squash;

    logic             w_full;
    logic             w_empty;
    logic [ENT_W-1:0] w_buf_data;
    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_keep_req;
    logic             w_squash_next;
    logic [AW-1:0]    w_pc_next;
    logic [1:0]       w_cnt;
    logic [1:0]       w_cnt_next;
    logic             w_space;

    // An ack only counts against a request we actually issued; stray acks are ignored.
    assign w_ack         = r_mem_req && mem_ack;
    assign w_push        = w_ack && !r_squash && !br_taken;
    assign w_pop         = !w_empty && ins_ready;
    assign w_keep_req    = r_mem_req && !mem_ack;
    // A redirect cannot cancel an issued request, so its data is dropped when it returns.
    assign w_squash_next = w_keep_req && (r_squash || br_taken);
    assign w_pc_next     = br_taken ? br_target : (w_push ? r_pc + AW'(1) : r_pc);
    assign w_cnt         = w_full ? 2'(BUF_DEPTH) : {1'b0, !w_empty};
    assign w_cnt_next    = br_taken ? 2'd0 : (w_cnt + {1'b0, w_push} - {1'b0, w_pop});
    assign w_space       = (w_cnt_next < 2'(BUF_DEPTH));

    ifetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (ENT_W)
    ) u_buf (
        .clk     (clk),
        .rst_f   (rst_f),
        .i_push  (w_push),
        .i_data  ({mem_rdata, r_pc}),
        .i_pop   (w_pop),
        .i_flush (br_taken),
        .o_data  (w_buf_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state    <= ST_IDLE;
            r_pc       <= AW'(RESET_PC);
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_squash   <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_squash <= w_squash_next;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_pc_next;
                end
                default: begin
                    if (w_keep_req) begin
                        r_state <= ST_FETCH;
                    end else if (w_space) begin
                        r_state    <= ST_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_next;
                    end else begin
                        r_state   <= ST_HOLD;
                        r_mem_req <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_req               = r_mem_req;
    assign mem_addr              = r_mem_addr;
    assign ins_valid             = !w_empty;
    assign {instruction, ins_pc} = w_buf_data;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected delivered words.
module tb_instr_fetch;

    logic        clk;
    logic        rst_f;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        br_taken;
    logic [15:0] br_target;
    logic [31:0] instruction;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_pc;

    int tests = 0;
    int fails = 0;
    logic [47:0] sb [$];

`ifdef IFETCH_PREFETCH_EN
    localparam logic EXP_PREF_REQ = 1'b1;
    localparam int   START_A      = 2;
`else
    localparam logic EXP_PREF_REQ = 1'b0;
    localparam int   START_A      = 1;
`endif

    instr_fetch #(.AW(16), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instruction (instruction),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_pc      (ins_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] data_of(input logic [15:0] a);
        return (a == 16'h0000) ? 32'h12345678 : {16'hA5A5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!mem_req && n < 20) begin
            tick;
            n++;
        end
        chk("req_timeout", mem_req, 1);
    endtask

    task automatic fetch(input logic [15:0] a, input int lat);
        wait_req;
        chk("req_addr", mem_addr, a);
        repeat (lat) begin
            tick;
            chk("req_hold", {mem_req, mem_addr}, {1'b1, a});
        end
        mem_rdata = data_of(a);
        mem_ack   = 1'b1;
        sb.push_back({data_of(a), a});
        tick;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Every transfer seen by the core must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst_f && ins_valid && ins_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                chk("xfer_word", {instruction, ins_pc}, sb.pop_front());
            end
        end
    end

    initial begin
        rst_f = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        br_taken = 1'b0; br_target = '0; ins_ready = 1'b0;
        tick; tick;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_pc", ins_pc, 0);

        rst_f = 1'b0;
        tick;
        chk("first_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
        fetch(16'h0000, 1);
        chk("first_valid", ins_valid, 1);
        chk("first_instr", instruction, 32'h12345678);
        chk("first_pc", ins_pc, 0);
        chk("pref_req", mem_req, EXP_PREF_REQ);

        for (int i = 0; i < 5; i++) begin
`ifdef IFETCH_PREFETCH_EN
            if (i == 0) begin
                chk("pref_addr", mem_addr, 16'h0001);
                mem_rdata = data_of(16'h0001);
                mem_ack   = 1'b1;
                sb.push_back({data_of(16'h0001), 16'h0001});
            end
`endif
            tick;
            mem_ack = 1'b0;
            chk("stall_instr", instruction, 32'h12345678);
            chk("stall_pc", ins_pc, 0);
            chk("stall_noreq", mem_req, 0);
        end

        ins_ready = 1'b1;
        tick;
        for (int a = START_A; a < 3; a++) fetch(16'(a), 1);
        wait_req;
        chk("req3_addr", mem_addr, 16'h0003);
        br_taken = 1'b1; br_target = 16'h0040;
        tick;
        br_taken = 1'b0;
        chk("br_out_hold", {mem_req, mem_addr}, {1'b1, 16'h0003});
        chk("br_flushed", ins_valid, 0);
        mem_rdata = 32'hDEAD0003; mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk("br_redirect", {mem_req, mem_addr}, {1'b1, 16'h0040});
        chk("br_squashed", ins_valid, 0);
        fetch(16'h0040, 1);

        wait_req;
        chk("req41_addr", mem_addr, 16'h0041);
        mem_rdata = 32'hBAD00041; mem_ack = 1'b1;
        br_taken = 1'b1; br_target = 16'h0010;
        tick;
        mem_ack = 1'b0; br_taken = 1'b0;
        chk("ackbr_redirect", {mem_req, mem_addr}, {1'b1, 16'h0010});
        chk("ackbr_discard", ins_valid, 0);
        fetch(16'h0010, 0);

        wait_req;
        chk("req11_addr", mem_addr, 16'h0011);
        mem_rdata = 32'hBAD00011; mem_ack = 1'b1;
        br_taken = 1'b1; br_target = 16'hFFFF;
        tick;
        mem_ack = 1'b0; br_taken = 1'b0;
        fetch(16'hFFFF, 0);
        wait_req;
        chk("pc_wrap", mem_addr, 16'h0000);
        fetch(16'h0000, 0);

        wait_req;
        rst_f = 1'b1;
        tick;
        sb.delete();
        chk("midrst_req", mem_req, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_valid", ins_valid, 0);
        chk("midrst_instr", instruction, 0);
        chk("midrst_pc", ins_pc, 0);
        mem_rdata = 32'hBAD0BAD0; mem_ack = 1'b1;
        tick;
        rst_f = 1'b0;
        tick;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("post_rst_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
        chk("post_rst_stray", ins_valid, 0);
        fetch(16'h0000, 1);
        repeat (4) tick;
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 16, program-counter and memory address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_f, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port mem_req, output, 1, instruction-memory read request.
REQ-006 Port mem_addr, output, AW, word address of the requested instruction.
REQ-007 Port mem_ack, input, 1, memory has returned mem_rdata this cycle.
REQ-008 Port mem_rdata, input, 32, instruction word from memory.
REQ-009 Port br_taken, input, 1, redirect request from the core.
REQ-010 Port br_target, input, AW, redirect address.
REQ-011 Port instruction, output, 32, instruction word delivered to the core.
REQ-012 Port ins_valid, output, 1, instruction and ins_pc are valid.
REQ-013 Port ins_ready, input, 1, core accepts the instruction this cycle.
REQ-014 Port ins_pc, output, AW, address of the word on instruction.

Function
REQ-015 Fetch FSM SHALL have states IDLE, FETCH and HOLD.
REQ-016 IDLE -> FETCH when there is buffer space: mem_req=1, mem_addr=PC.
REQ-017 In FETCH, mem_req and mem_addr SHALL stay stable until the mem_ack cycle.
REQ-018 On mem_ack, data SHALL be registered; ins_valid rises the next cycle (1-cycle latency); PC <= PC+1.
REQ-019 PC increment SHALL wrap modulo 2^AW (all-ones -> 0), with no flag.
REQ-020 FETCH -> HOLD when the buffer becomes full; HOLD -> FETCH on transfer (ins_valid && ins_ready).
REQ-021 While ins_valid=1 and ins_ready=0, instruction and ins_pc SHALL remain stable.
REQ-022 On br_taken, the block SHALL flush all buffered words (ins_valid=0 next cycle) and set PC <= br_target.
REQ-023 If a fetch is outstanding on br_taken, its later mem_ack data SHALL be squashed; the fetch of br_target is issued the cycle after that ack.
REQ-024 br_taken and mem_ack in the same cycle: the acked data is discarded; the next request uses br_target.
REQ-025 br_taken and a transfer in the same cycle: the transfer completes; everything else is flushed.
REQ-026 The block SHALL never hold more than one memory request outstanding.

Reset
REQ-027 On rst_f=1 at a clock edge: state=IDLE, PC=RESET_PC, mem_req=0, mem_addr=0, ins_valid=0, instruction=0, ins_pc=0, squash flag=0, buffer empty.
REQ-028 Reset mid-fetch SHALL drop the request next cycle and ignore any later mem_ack until a new request issues.
REQ-029 The first mem_req (addr RESET_PC) SHALL assert in the first cycle after rst_f deasserts.

Configuration
REQ-030 Macro IFETCH_PREFETCH_EN defined: 2-entry FIFO buffer; the next fetch issues while one word is held; back-to-back transfers at one per cycle are possible when memory acks each cycle.
REQ-031 Macro undefined: 1-entry buffer; the next fetch issues only after the held word transfers.

Structure
REQ-032 Shared package: FSM state enum, RESET_PC default, and the instruction width constant (32).
REQ-033 Sub-module ifetch_buf holds the 1/2-entry instruction+PC buffer with push/pop/flush and full/empty outputs; the FSM and PC stay in instr_fetch.

Verification
REQ-034 Reset release, mem_ack 2 cycles after request with rdata=0x12345678 -> mem_addr=0; then ins_valid=1 with instruction=0x12345678 and ins_pc=0 one cycle after the ack.
REQ-035 ins_ready=0 for 5 cycles while valid -> instruction and ins_pc constant; no second request issues without IFETCH_PREFETCH_EN; exactly one issues with it.
REQ-036 br_taken, br_target=0x0040 while a fetch of 0x0003 is outstanding -> ack data dropped, next mem_addr=0x0040, no ins_valid for 0x0003.
REQ-037 PC=0xFFFF fetched -> next mem_addr=0x0000.
REQ-038 Same-cycle mem_ack and br_taken (target 0x0010) -> data discarded; the next request is to 0x0010.
REQ-039 rst_f asserted mid-FETCH, then a stray mem_ack -> outputs at reset values; the first request after release is to RESET_PC.
